key_debounce: RTL and testbench

//   Conditions the raw, active-low, bouncing DE2 push buttons (KEY[3:0])

---
 rtl/key_debounce_if.sv | 23 ++
 rtl/key_debounce.sv | 91 +++++++++
 tb/tb_key_debounce.sv | 133 +++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// Key channel bundle: raw active-low buttons in, debounced level and edge strobes out.
interface key_debounce_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;

    modport master (
        output key_n,
        input  pressed,
        input  press_pulse,
        input  release_pulse
    );

    modport slave (
        input  key_n,
        output pressed,
        output press_pulse,
        output release_pulse
    );
endinterface

// File: rtl/key_debounce.sv
// Per-key two-flop synchronizer followed by a stability-counter debouncer.
// A new level must be seen for STABLE_CYCLES consecutive samples before it is accepted.
module key_debounce #(
    parameter int NUM_KEYS      = 4,
    parameter int STABLE_CYCLES = 1_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    key_debounce_if.slave  bus
);

    localparam int              CW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STABLE,
        ST_CHANGING,
        ST_ACCEPT
    } phase_e;

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] r_pressed;
    logic [NUM_KEYS-1:0] r_press_pulse;
    logic [NUM_KEYS-1:0] r_release_pulse;
    logic [CW-1:0]       r_cnt [NUM_KEYS];

    logic [NUM_KEYS-1:0] w_sample;
    logic [NUM_KEYS-1:0] w_pressed_nxt;
    logic [NUM_KEYS-1:0] w_press_nxt;
    logic [NUM_KEYS-1:0] w_release_nxt;
    logic [CW-1:0]       w_cnt_nxt [NUM_KEYS];
    phase_e              w_phase   [NUM_KEYS];

    assign w_sample = ~r_sync2;

    // Next-state: classify each channel, then advance its counter and level.
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            // NOTE: every comb output gets a default before any branch, so no latch can be inferred.
            w_phase[i]       = ST_STABLE;
            w_cnt_nxt[i]     = '0;
            w_pressed_nxt[i] = r_pressed[i];
            if (w_sample[i] != r_pressed[i]) begin
                w_phase[i] = (r_cnt[i] == CNT_MAX) ? ST_ACCEPT : ST_CHANGING;
            end
            case (w_phase[i])
                ST_CHANGING: w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                ST_ACCEPT:   w_pressed_nxt[i] = w_sample[i];
                default:     w_cnt_nxt[i] = '0;
            endcase
        end
    end

    // Output: strobes fire only on the accepting cycle, polarity set by the new level.
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            w_press_nxt[i]   = (w_phase[i] == ST_ACCEPT) &&  w_sample[i];
            w_release_nxt[i] = (w_phase[i] == ST_ACCEPT) && !w_sample[i];
        end
    end

    // Synchronizer idles at 1 so a held-released key reads as released out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1         <= '1;
            r_sync2         <= '1;
            r_pressed       <= '0;
            r_press_pulse   <= '0;
            r_release_pulse <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            // NOTE: state uses non-blocking assignment so sync1->sync2 shifts by one edge, not zero.
            r_sync1         <= bus.key_n;
            r_sync2         <= r_sync1;
            r_pressed       <= w_pressed_nxt;
            r_press_pulse   <= w_press_nxt;
            r_release_pulse <= w_release_nxt;
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign bus.pressed       = r_pressed;
    assign bus.press_pulse   = r_press_pulse;
    assign bus.release_pulse = r_release_pulse;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with STABLE_CYCLES=4: latency, bounce rejection, pulses, reset.
module tb_key_debounce;

    localparam int NK = 4;
    localparam int SC = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    key_debounce_if #(.NUM_KEYS(NK)) bus ();

    key_debounce #(
        .NUM_KEYS      (NK),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit so outputs are sampled off the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.key_n = 4'hF;

        // 1: reset with all keys released
        tick(2);
        check("rst_pressed",  32'(bus.pressed),       32'h0);
        check("rst_ppulse",   32'(bus.press_pulse),   32'h0);
        check("rst_rpulse",   32'(bus.release_pulse), 32'h0);
        rst_n = 1'b1;
        tick(8);
        check("post_rst_pressed", 32'(bus.pressed),     32'h0);
        check("post_rst_ppulse",  32'(bus.press_pulse), 32'h0);

        // 2: clean press on key 0, accepted at the 6th edge (k+5)
        bus.key_n[0] = 1'b0;
        tick(5);
        check("press0_early",  32'(bus.pressed[0]),     32'h0);
        tick(1);
        check("press0_level",  32'(bus.pressed[0]),     32'h1);
        check("press0_pulse",  32'(bus.press_pulse[0]), 32'h1);
        check("press0_others", 32'(bus.pressed[3:1]),   32'h0);
        tick(1);
        check("press0_pulse_off", 32'(bus.press_pulse[0]), 32'h0);
        check("press0_hold",      32'(bus.pressed[0]),     32'h1);

        // 4: release key 0
        bus.key_n[0] = 1'b1;
        tick(5);
        check("rel0_early",  32'(bus.pressed[0]),       32'h1);
        tick(1);
        check("rel0_level",  32'(bus.pressed[0]),       32'h0);
        check("rel0_rpulse", 32'(bus.release_pulse[0]), 32'h1);
        check("rel0_ppulse", 32'(bus.press_pulse[0]),   32'h0);
        tick(1);
        check("rel0_rpulse_off", 32'(bus.release_pulse[0]), 32'h0);

        // 3: bounce on key 1 -- 3 low samples, 1 high, then held low
        bus.key_n[1] = 1'b0;
        tick(3);
        bus.key_n[1] = 1'b1;
        tick(1);
        bus.key_n[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check($sformatf("bounce1_level_%0d", i), 32'(bus.pressed[1]),     32'h0);
            check($sformatf("bounce1_pulse_%0d", i), 32'(bus.press_pulse[1]), 32'h0);
        end
        tick(1);
        check("bounce1_level", 32'(bus.pressed[1]),     32'h1);
        check("bounce1_pulse", 32'(bus.press_pulse[1]), 32'h1);
        bus.key_n[1] = 1'b1;
        tick(8);
        check("bounce1_released", 32'(bus.pressed), 32'h0);

        // 5: all keys pressed together
        bus.key_n = 4'h0;
        tick(5);
        check("all_early",  32'(bus.pressed),     32'h0);
        tick(1);
        check("all_level",  32'(bus.pressed),     32'hF);
        check("all_pulse",  32'(bus.press_pulse), 32'hF);
        check("all_rpulse", 32'(bus.release_pulse), 32'h0);
        tick(1);
        check("all_pulse_off", 32'(bus.press_pulse), 32'h0);
        bus.key_n = 4'hF;
        tick(8);
        check("all_released", 32'(bus.pressed), 32'h0);

        // 6: reset in the middle of counting a press on key 2
        bus.key_n[2] = 1'b0;
        tick(2);
        rst_n = 1'b0;
        #1;
        check("midrst_level", 32'(bus.pressed[2]), 32'h0);
        tick(2);
        check("midrst_hold",  32'(bus.pressed),     32'h0);
        check("midrst_pulse", 32'(bus.press_pulse), 32'h0);
        rst_n = 1'b1;
        tick(5);
        check("midrst_early", 32'(bus.pressed[2]),     32'h0);
        tick(1);
        check("midrst_level_after", 32'(bus.pressed[2]),     32'h1);
        check("midrst_pulse_after", 32'(bus.press_pulse[2]), 32'h1);
        tick(1);
        check("midrst_pulse_off", 32'(bus.press_pulse[2]), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
